// File: rtl/sched_pkg.sv
// Shared types and default widths for the round-robin process scheduler.
// Optional SCHED_STATS_EN build adds per-slot dispatch counters in proc_scheduler.
package sched_pkg;

   localparam int ADDR_WIDTH_DEF = 5;
   localparam int PID_BITS_DEF   = 3;

   typedef enum logic [1:0] {
      SLOT_FREE,
      SLOT_READY,
      SLOT_HALTED
   } slot_state_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAVE,
      ST_SEARCH,
      ST_DISPATCH,
      ST_NONE
   } sched_state_t;

endpackage

// File: rtl/sched_rr_scan.sv
// Round-robin scan index: walks start_idx+1 .. start_idx, one slot per stepped cycle.
module sched_rr_scan #(
   parameter int PID_BITS = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PID_BITS-1:0] start_idx,
   input  logic                step,
   input  logic                slot_ready,
   output logic                hit,
   output logic [PID_BITS-1:0] hit_idx,
   output logic                exhausted
);

   localparam logic [PID_BITS-1:0] ONE = {{(PID_BITS-1){1'b0}}, 1'b1};

   logic [PID_BITS-1:0] cnt_q, cnt_d;

   // The offset wraps naturally, so the last probe lands back on start_idx itself.
   assign hit_idx   = start_idx + ONE + cnt_q;
   assign hit       = step && slot_ready;
   assign exhausted = step && !slot_ready && (cnt_q == {PID_BITS{1'b1}});

   always_comb begin
      cnt_d = '0;
      if (step && !slot_ready && !exhausted) begin
         cnt_d = cnt_q + ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/proc_scheduler.sv
// Round-robin process scheduler feeding the PC stage with context switches.
// Define SCHED_STATS_EN for per-slot saturating dispatch counters (stat_pid/stat_count).
module proc_scheduler
   import sched_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int PID_BITS   = PID_BITS_DEF,
   localparam int DW        = 2**ADDR_WIDTH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                quantum,
   input  logic                halt,
   input  logic [DW-1:0]       cur_pc,
   input  logic                start,
   input  logic                create_valid,
   input  logic [PID_BITS-1:0] create_pid,
   input  logic [DW-1:0]       create_pc,
   input  logic [DW-1:0]       create_base,
   output logic                create_ready,
   output logic                dispatch,
   output logic [DW-1:0]       next_pc,
   output logic [DW-1:0]       next_base,
   output logic [PID_BITS-1:0] next_pid,
   output logic                running,
   output logic                none_ready
`ifdef SCHED_STATS_EN
   ,
   input  logic [PID_BITS-1:0] stat_pid,
   output logic [15:0]         stat_count
`endif
);

   localparam int NPROC = 2**PID_BITS;

   sched_state_t        state_q, state_d;
   logic [DW-1:0]       pc_q   [NPROC];
   logic [DW-1:0]       base_q [NPROC];
   slot_state_t         slot_q [NPROC];
   logic [PID_BITS-1:0] cur_pid_q;
   logic [PID_BITS-1:0] next_pid_q;
   logic [DW-1:0]       next_pc_q;
   logic [DW-1:0]       next_base_q;
   logic                running_q;
   logic                save_halt_q;

   logic                scan_step;
   logic                scan_ready;
   logic                scan_hit;
   logic                scan_exhausted;
   logic [PID_BITS-1:0] scan_idx;

   assign scan_step  = (state_q == ST_SEARCH);
   assign scan_ready = (slot_q[scan_idx] == SLOT_READY);

   sched_rr_scan #(.PID_BITS(PID_BITS)) u_scan (
      .clk        (clk),
      .reset      (reset),
      .start_idx  (cur_pid_q),
      .step       (scan_step),
      .slot_ready (scan_ready),
      .hit        (scan_hit),
      .hit_idx    (scan_idx),
      .exhausted  (scan_exhausted)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (running_q && (halt || quantum)) begin
               state_d = ST_SAVE;
            end else if (!running_q && start) begin
               state_d = ST_SEARCH;
            end
         end
         ST_SAVE:     state_d = ST_SEARCH;
         ST_SEARCH: begin
            if (scan_hit) begin
               state_d = ST_DISPATCH;
            end else if (scan_exhausted) begin
               state_d = ST_NONE;
            end
         end
         ST_DISPATCH: state_d = ST_IDLE;
         ST_NONE:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Creates only land in IDLE and saves only in SAVE, so the table has one writer per cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NPROC; i++) begin
            pc_q[i]   <= '0;
            base_q[i] <= '0;
            slot_q[i] <= SLOT_FREE;
         end
      end else begin
         if (state_q == ST_IDLE && create_valid) begin
            pc_q[create_pid]   <= create_pc;
            base_q[create_pid] <= create_base;
            slot_q[create_pid] <= SLOT_READY;
         end
         if (state_q == ST_SAVE) begin
            pc_q[cur_pid_q]   <= cur_pc;
            slot_q[cur_pid_q] <= save_halt_q ? SLOT_HALTED : SLOT_READY;
         end
      end
   end

   // next_* load on the scan hit so they are already valid during the dispatch pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cur_pid_q   <= {PID_BITS{1'b1}};
         next_pid_q  <= '0;
         next_pc_q   <= '0;
         next_base_q <= '0;
         running_q   <= 1'b0;
         save_halt_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE) begin
            save_halt_q <= halt;
         end
         if (scan_hit) begin
            next_pid_q  <= scan_idx;
            next_pc_q   <= pc_q[scan_idx];
            next_base_q <= base_q[scan_idx];
         end
         if (state_q == ST_SAVE) begin
            running_q <= 1'b0;
         end
         if (state_q == ST_DISPATCH) begin
            running_q <= 1'b1;
            cur_pid_q <= next_pid_q;
         end
      end
   end

   assign create_ready = (state_q == ST_IDLE);
   assign dispatch     = (state_q == ST_DISPATCH);
   assign none_ready   = (state_q == ST_NONE);
   assign running      = running_q;
   assign next_pid     = next_pid_q;
   assign next_pc      = next_pc_q;
   assign next_base    = next_base_q;

`ifdef SCHED_STATS_EN
   logic [15:0] stat_q [NPROC];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NPROC; i++) begin
            stat_q[i] <= '0;
         end
      end else begin
         if (state_q == ST_IDLE && create_valid) begin
            stat_q[create_pid] <= '0;
         end
         if (state_q == ST_DISPATCH && stat_q[next_pid_q] != 16'hFFFF) begin
            stat_q[next_pid_q] <= stat_q[next_pid_q] + 16'd1;
         end
      end
   end

   assign stat_count = stat_q[stat_pid];
`endif

endmodule

// File: tb/tb_proc_scheduler.sv
// Scoreboard bench for proc_scheduler: directed context switches with hand-computed results.
module tb_proc_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        quantum;
   logic        halt;
   logic [31:0] cur_pc;
   logic        start;
   logic        create_valid;
   logic [2:0]  create_pid;
   logic [31:0] create_pc;
   logic [31:0] create_base;
   logic        create_ready;
   logic        dispatch;
   logic [31:0] next_pc;
   logic [31:0] next_base;
   logic [2:0]  next_pid;
   logic        running;
   logic        none_ready;
`ifdef SCHED_STATS_EN
   logic [2:0]  stat_pid = 3'd0;
   logic [15:0] stat_count;
`endif

   typedef struct {
      logic        isNone;
      logic [2:0]  pid;
      logic [31:0] pc;
      logic [31:0] base;
   } exp_t;

   exp_t sbQ[$];
   int   checks = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   proc_scheduler dut (
      .clk          (clk),
      .reset        (reset),
      .quantum      (quantum),
      .halt         (halt),
      .cur_pc       (cur_pc),
      .start        (start),
      .create_valid (create_valid),
      .create_pid   (create_pid),
      .create_pc    (create_pc),
      .create_base  (create_base),
      .create_ready (create_ready),
      .dispatch     (dispatch),
      .next_pc      (next_pc),
      .next_base    (next_base),
      .next_pid     (next_pid),
      .running      (running),
      .none_ready   (none_ready)
`ifdef SCHED_STATS_EN
      ,
      .stat_pid     (stat_pid),
      .stat_count   (stat_count)
`endif
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: actual 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every dispatch or none_ready pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!reset && (dispatch || none_ready)) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected event", {30'd0, dispatch, none_ready}, 32'd0);
         end else begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput("event kind none_ready", {31'd0, none_ready}, {31'd0, e.isNone});
            checkOutput("event kind dispatch", {31'd0, dispatch}, {31'd0, !e.isNone});
            if (!e.isNone) begin
               checkOutput("next_pid", {29'd0, next_pid}, {29'd0, e.pid});
               checkOutput("next_pc", next_pc, e.pc);
               checkOutput("next_base", next_base, e.base);
            end
         end
      end
   end

   task automatic expectDispatch(input logic [2:0] pid, input logic [31:0] pc, input logic [31:0] base);
      exp_t e;
      e.isNone = 1'b0;
      e.pid    = pid;
      e.pc     = pc;
      e.base   = base;
      sbQ.push_back(e);
   endtask

   task automatic expectNone();
      exp_t e;
      e.isNone = 1'b1;
      e.pid    = '0;
      e.pc     = '0;
      e.base   = '0;
      sbQ.push_back(e);
   endtask

   task automatic createSlot(input logic [2:0] pid, input logic [31:0] pc, input logic [31:0] base);
      @(negedge clk);
      checkOutput("create_ready", {31'd0, create_ready}, 32'd1);
      create_valid = 1'b1;
      create_pid   = pid;
      create_pc    = pc;
      create_base  = base;
      @(negedge clk);
      create_valid = 1'b0;
   endtask

   // Drives one request cycle, then waits (bounded) for the resulting dispatch/none_ready.
   task automatic applyStimulus(input logic q, input logic h, input logic s, input logic [31:0] pc,
                                input string name, input int expLat);
      int n;
      bit found;
      n     = 0;
      found = 1'b0;
      @(negedge clk);
      quantum = q;
      halt    = h;
      start   = s;
      cur_pc  = pc;
      while (n < 40 && !found) begin
         @(negedge clk);
         n++;
         quantum = 1'b0;
         halt    = 1'b0;
         start   = 1'b0;
         if (dispatch || none_ready) found = 1'b1;
      end
      checkOutput(name, found ? n : 32'hFFFF_FFFF, expLat);
   endtask

   task automatic checkRunning(input logic exp);
      @(negedge clk);
      checkOutput("running", {31'd0, running}, {31'd0, exp});
   endtask

   initial begin
      int evt;
      reset        = 1'b1;
      quantum      = 1'b0;
      halt         = 1'b0;
      cur_pc       = '0;
      start        = 1'b0;
      create_valid = 1'b0;
      create_pid   = '0;
      create_pc    = '0;
      create_base  = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset dispatch", {31'd0, dispatch}, 32'd0);
      checkOutput("reset running", {31'd0, running}, 32'd0);
      checkOutput("reset none_ready", {31'd0, none_ready}, 32'd0);
      checkOutput("reset next_pc", next_pc, 32'd0);
      checkOutput("reset next_base", next_base, 32'd0);
      checkOutput("reset next_pid", {29'd0, next_pid}, 32'd0);
      checkOutput("reset create_ready", {31'd0, create_ready}, 32'd1);

      // First dispatch from a cold start.
      createSlot(3'd0, 32'h40, 32'h100);
      expectDispatch(3'd0, 32'h40, 32'h100);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, "start latency", 2);
      checkRunning(1'b1);

      // Quantum rotation 0 -> 1 -> 2 -> 0, with slot0 PC saved as 0x58.
      createSlot(3'd1, 32'h80, 32'h200);
      createSlot(3'd2, 32'hC0, 32'h300);
      expectDispatch(3'd1, 32'h80, 32'h200);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h58, "quantum 0->1 latency", 3);
      checkRunning(1'b1);
      expectDispatch(3'd2, 32'hC0, 32'h300);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h84, "quantum 1->2 latency", 3);
      expectDispatch(3'd0, 32'h58, 32'h100);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'hC8, "quantum 2->0 wrap latency", 8);

      // Halt beats quantum; halted pid3 is skipped afterwards.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      createSlot(3'd1, 32'h100, 32'h10);
      createSlot(3'd3, 32'h300, 32'h30);
      expectDispatch(3'd1, 32'h100, 32'h10);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, "start to pid1 latency", 3);
      expectDispatch(3'd3, 32'h300, 32'h30);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h104, "quantum 1->3 latency", 4);
      expectDispatch(3'd1, 32'h104, 32'h10);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h308, "halt+quantum 3->1 latency", 8);
      expectDispatch(3'd1, 32'h110, 32'h10);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h110, "skip halted latency", 10);

      // Last process halts: full scan, then none_ready.
      expectNone();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h120, "none_ready latency", 10);
      checkRunning(1'b0);
      checkOutput("held next_pid", {29'd0, next_pid}, 32'd1);
      checkOutput("held next_pc", next_pc, 32'h110);

      // Not running: quantum/halt must not start anything.
      @(negedge clk);
      quantum = 1'b1;
      halt    = 1'b1;
      evt     = 0;
      repeat (14) begin
         @(negedge clk);
         quantum = 1'b0;
         halt    = 1'b0;
         if (dispatch || none_ready) evt++;
      end
      checkOutput("idle quantum ignored", evt, 32'd0);

      // Lone READY process redispatches itself with the saved PC.
      createSlot(3'd5, 32'h500, 32'h50);
      expectDispatch(3'd5, 32'h500, 32'h50);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, "start to pid5 latency", 5);
      expectDispatch(3'd5, 32'h7C, 32'h50);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h7C, "lone redispatch latency", 10);
      checkRunning(1'b1);

      // Reset in the middle of a scan clears everything immediately.
      @(negedge clk);
      quantum = 1'b1;
      cur_pc  = 32'h80;
      @(negedge clk);
      quantum = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("midreset dispatch", {31'd0, dispatch}, 32'd0);
      checkOutput("midreset running", {31'd0, running}, 32'd0);
      checkOutput("midreset none_ready", {31'd0, none_ready}, 32'd0);
      checkOutput("midreset next_pc", next_pc, 32'd0);
      checkOutput("midreset next_base", next_base, 32'd0);
      checkOutput("midreset next_pid", {29'd0, next_pid}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      expectNone();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, "empty table none latency", 9);
      checkRunning(1'b0);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard drained", sbQ.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
